// File: rtl/clock_pkg.sv
// Shared segment codes and BCD helpers for the HH:MM:SS timekeeper.
// Segment vectors are gfedcba with bit 0 = a, active-low.
package clock_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // {tens, ones} for 0..59
  function automatic logic [7:0] bin2bcd2(
    input logic [5:0] v
  );
    logic [5:0] t;
    logic [5:0] o;
    t = v / 6'd10;
    o = v - t * 6'd10;
    return {t[3:0], o[3:0]};
  endfunction

  function automatic logic [4:0] hour_12(
    input logic [4:0] h
  );
    logic [4:0] r;
    r = h;
    if (h == 5'd0)
      r = 5'd12;
    else if (h > 5'd12)
      r = h - 5'd12;
    return r;
  endfunction

  function automatic logic [6:0] seg7(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0: s = SEG_0;
      4'd1: s = SEG_1;
      4'd2: s = SEG_2;
      4'd3: s = SEG_3;
      4'd4: s = SEG_4;
      4'd5: s = SEG_5;
      4'd6: s = SEG_6;
      4'd7: s = SEG_7;
      4'd8: s = SEG_8;
      4'd9: s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with a combinational wrap strobe.
// wrap flags the increment that returns the count to zero.
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         cp,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         wrap
);

  assign wrap = inc && (q == W'(MOD - 1));

  always_ff @(posedge cp) begin
    if (reset)
      q <= '0;
    else if (inc)
      q <= wrap ? '0 : q + W'(1);
  end

endmodule

// File: rtl/timekeeper_mux.sv
// HH:MM:SS timekeeper with run/set modes, 12/24 h display,
// top-of-hour chime and a multiplexed 7-segment scan driver.
module timekeeper_mux
  import clock_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 65536,
  parameter int DIGITS     = 8,
  parameter int CHIME_SECS = 5
) (
  input  logic              cp,
  input  logic              reset,
  input  logic              run,
  input  logic              sec_inc,
  input  logic              min_inc,
  input  logic              hour_inc,
  input  logic              mode_12h,
  output logic [DIGITS-1:0] which_led,
  output logic [6:0]        led_display,
  output logic              pm,
  output logic              chime
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(CHIME_SECS + 1);

  logic [TW-1:0] div;
  logic          tick;

  assign tick = run && (div == TW'(TICK_DIV - 1));

  always_ff @(posedge cp) begin
    if (reset || !run || tick)
      div <= '0;
    else
      div <= div + TW'(1);
  end

  // Edge register tracks the inputs even in reset and run mode,
  // so a level held across either never looks like a fresh press.
  logic [2:0] prev;
  logic [2:0] edges;

  always_ff @(posedge cp) begin
    prev <= {hour_inc, min_inc, sec_inc};
  end

  assign edges = {hour_inc, min_inc, sec_inc} & ~prev;

  logic [5:0] sec_q;
  logic [5:0] min_q;
  logic [4:0] hour_q;
  logic       sec_wrap;
  logic       min_wrap;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;

  assign sec_en  = run ? tick     : edges[0];
  assign min_en  = run ? sec_wrap : edges[1];
  assign hour_en = run ? min_wrap : edges[2];

  mod_counter #(.MOD(60), .W(6)) u_sec (
    .cp    (cp),
    .reset (reset),
    .inc   (sec_en),
    .q     (sec_q),
    .wrap  (sec_wrap)
  );

  mod_counter #(.MOD(60), .W(6)) u_min (
    .cp    (cp),
    .reset (reset),
    .inc   (min_en),
    .q     (min_q),
    .wrap  (min_wrap)
  );

  mod_counter #(.MOD(24), .W(5)) u_hour (
    .cp    (cp),
    .reset (reset),
    .inc   (hour_en),
    .q     (hour_q),
    .wrap  ()
  );

  logic [CW-1:0] chime_cnt;

  // In run mode min_wrap implies a tick that lands on MM:SS = 00:00
  always_ff @(posedge cp) begin
    if (reset || !run) begin
      chime     <= 1'b0;
      chime_cnt <= '0;
    end else if (min_wrap) begin
      chime     <= 1'b1;
      chime_cnt <= '0;
    end else if (chime && tick) begin
      if (chime_cnt == CW'(CHIME_SECS - 1))
        chime <= 1'b0;
      else
        chime_cnt <= chime_cnt + CW'(1);
    end
  end

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;

  always_ff @(posedge cp) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

  logic [4:0] hour_disp;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic [3:0] nib;
  logic       blank;
  logic [6:0] seg;

  always_comb begin
    hour_disp = mode_12h ? hour_12(hour_q) : hour_q;
    sec_bcd   = bin2bcd2(sec_q);
    min_bcd   = bin2bcd2(min_q);
    hour_bcd  = bin2bcd2({1'b0, hour_disp});
    nib       = 4'd0;
    blank     = 1'b0;
    unique case (idx)
      IW'(0):  nib = sec_bcd[3:0];
      IW'(1):  nib = sec_bcd[7:4];
      IW'(2):  nib = min_bcd[3:0];
      IW'(3):  nib = min_bcd[7:4];
      IW'(4):  nib = hour_bcd[3:0];
      IW'(5):  nib = hour_bcd[7:4];
      default: blank = 1'b1;
    endcase
    seg = blank ? SEG_BLANK : seg7(nib);
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      which_led   <= '1;
      led_display <= SEG_BLANK;
    end else begin
      which_led   <= ~(DIGITS'(1) << idx);
      led_display <= seg;
    end
  end

  assign pm = (hour_q >= 5'd12);

endmodule

// File: tb/tb_timekeeper_mux.sv
// Self-checking bench for timekeeper_mux against a seconds-of-day model.
// Directed scenarios followed by a randomized run/set/reset phase.
module tb_timekeeper_mux;

  localparam int TICK_DIV   = 4;
  localparam int SCAN_DIV   = 2;
  localparam int DIGITS     = 8;
  localparam int CHIME_SECS = 3;

  logic       cp = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       sec_inc = 1'b0;
  logic       min_inc = 1'b0;
  logic       hour_inc = 1'b0;
  logic       mode_12h = 1'b0;
  logic [7:0] which_led;
  logic [6:0] led_display;
  logic       pm;
  logic       chime;

  timekeeper_mux #(
    .TICK_DIV   (TICK_DIV),
    .SCAN_DIV   (SCAN_DIV),
    .DIGITS     (DIGITS),
    .CHIME_SECS (CHIME_SECS)
  ) dut (
    .cp          (cp),
    .reset       (reset),
    .run         (run),
    .sec_inc     (sec_inc),
    .min_inc     (min_inc),
    .hour_inc    (hour_inc),
    .mode_12h    (mode_12h),
    .which_led   (which_led),
    .led_display (led_display),
    .pm          (pm),
    .chime       (chime)
  );

  always #5 cp = ~cp;

  logic [6:0] segt [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int checks = 0;
  int errors = 0;
  int ticks_obs = 0;

  int mh, mm, ms;
  int mdiv, mrem, ncyc;
  bit mchime;
  bit [2:0] mprev;
  logic [7:0] e_which;
  logic [6:0] e_disp;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int digit_of(input int ix);
    int hh;
    hh = mh;
    if (mode_12h) hh = (mh % 12 == 0) ? 12 : mh % 12;
    case (ix)
      0: return ms % 10;
      1: return ms / 10;
      2: return mm % 10;
      3: return mm / 10;
      4: return hh % 10;
      default: return hh / 10;
    endcase
  endfunction

  task automatic model_step();
    bit [2:0] now;
    bit [2:0] e;
    bit tk;
    bit top;
    int ix;
    int t;
    now = {hour_inc, min_inc, sec_inc};
    if (reset) begin
      mh = 0; mm = 0; ms = 0;
      mdiv = 0; mrem = 0; ncyc = 0;
      mchime = 0;
      e_which = 8'hff;
      e_disp = 7'h7f;
      mprev = now;
    end else begin
      ix = (ncyc / SCAN_DIV) % DIGITS;
      ncyc++;
      e_which = ~(8'd1 << ix);
      e_disp = (ix < 6) ? segt[digit_of(ix)] : 7'h7f;
      tk = run && (mdiv == TICK_DIV - 1);
      mdiv = (run && !tk) ? mdiv + 1 : 0;
      e = now & ~mprev;
      mprev = now;
      top = 0;
      if (run) begin
        if (tk) begin
          t = (mh * 3600 + mm * 60 + ms + 1) % 86400;
          mh = t / 3600;
          mm = (t / 60) % 60;
          ms = t % 60;
          top = (t % 3600 == 0);
        end
      end else begin
        ms = (ms + int'(e[0])) % 60;
        mm = (mm + int'(e[1])) % 60;
        mh = (mh + int'(e[2])) % 24;
      end
      if (!run) mchime = 0;
      else if (top) begin
        mchime = 1;
        mrem = CHIME_SECS;
      end else if (mchime && tk) begin
        mrem--;
        if (mrem == 0) mchime = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge cp);
    model_step();
    #1;
    if (dut.tick === 1'b1) ticks_obs++;
    chk("which_led", which_led, e_which);
    chk("led_display", led_display, e_disp);
    chk("pm", pm, (mh >= 12));
    chk("chime", chime, mchime);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input bit h, input bit m, input bit s);
    {hour_inc, min_inc, sec_inc} = {h, m, s};
    step();
    {hour_inc, min_inc, sec_inc} = 3'b000;
    step();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    int dh, dm, ds, n;
    dh = (h - mh + 24) % 24;
    dm = (m - mm + 60) % 60;
    ds = (s - ms + 60) % 60;
    n = dh;
    if (dm > n) n = dm;
    if (ds > n) n = ds;
    for (int k = 0; k < n; k++) pulse(k < dh, k < dm, k < ds);
  endtask

  task automatic chk_time(input string tag, input int h, input int m,
                          input int s);
    chk({tag, "_hour"}, dut.hour_q, h);
    chk({tag, "_min"}, dut.min_q, m);
    chk({tag, "_sec"}, dut.sec_q, s);
  endtask

  initial begin
    int n;
    int t0;

    // reset state
    reset = 1'b1;
    step();
    chk("rst_which", which_led, 8'hff);
    chk("rst_disp", led_display, 7'h7f);
    chk_time("rst", 0, 0, 0);

    // free run from reset
    reset = 1'b0;
    run = 1'b1;
    steps(239);
    chk_time("run239", 0, 0, 59);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (dut.sec_wrap === 1'b1) n++;
      step();
    end
    chk("min_carry_cycles", n, 1);
    chk_time("run243", 0, 1, 0);

    // day rollover and chime length
    run = 1'b0;
    set_time(23, 59, 59);
    chk_time("preset", 23, 59, 59);
    run = 1'b1;
    steps(TICK_DIV);
    chk_time("rollover", 0, 0, 0);
    chk("chime_rise", chime, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (chime === 1'b1) n++;
      step();
    end
    chk("chime_cycles", n, TICK_DIV * CHIME_SECS);

    // set-mode simultaneous wraps, no carry, no tick
    run = 1'b0;
    step();
    t0 = ticks_obs;
    set_time(0, 59, 59);
    pulse(1'b0, 1'b1, 1'b1);
    chk_time("set_wrap", 0, 0, 0);
    chk("set_chime", chime, 0);
    chk("set_no_tick", ticks_obs - t0, 0);

    // 12 h display of hour 13 and hour 0
    mode_12h = 1'b1;
    set_time(13, 7, 42);
    for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) begin
      step();
      if (which_led == 8'b1110_1111) chk("h13_ones", led_display, segt[1]);
      if (which_led == 8'b1101_1111) chk("h13_tens", led_display, segt[0]);
      if (which_led == 8'b1011_1111) chk("blank6", led_display, 7'h7f);
      if (which_led == 8'b0111_1111) chk("blank7", led_display, 7'h7f);
    end
    chk("pm13", pm, 1);
    set_time(0, 7, 42);
    for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) begin
      step();
      if (which_led == 8'b1110_1111) chk("h0_ones", led_display, segt[2]);
      if (which_led == 8'b1101_1111) chk("h0_tens", led_display, segt[1]);
    end
    chk("pm0", pm, 0);
    mode_12h = 1'b0;

    // reset mid-chime
    set_time(0, 59, 59);
    run = 1'b1;
    steps(TICK_DIV);
    chk("chime_pre_rst", chime, 1);
    steps(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstc_chime", chime, 0);
    chk("rstc_which", which_led, 8'hff);
    chk("rstc_disp", led_display, 7'h7f);
    chk("rstc_pm", pm, 0);

    // reset on the same cycle as a set edge
    run = 1'b0;
    steps(2);
    sec_inc = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rste_which", which_led, 8'hff);
    steps(3);
    chk_time("rste", 0, 0, 0);
    sec_inc = 1'b0;
    step();

    // randomized mix of run, set edges, mode and reset
    run = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 3) == 0) sec_inc = ~sec_inc;
      if ($urandom_range(0, 3) == 0) min_inc = ~min_inc;
      if ($urandom_range(0, 3) == 0) hour_inc = ~hour_inc;
      if ($urandom_range(0, 59) == 0) mode_12h = ~mode_12h;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    run = 1'b0;
    {hour_inc, min_inc, sec_inc} = 3'b000;
    step();
    set_time($urandom_range(0, 23), $urandom_range(0, 59),
             $urandom_range(0, 59));
    run = 1'b1;
    steps(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
